// File: rtl/sba_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sba_pkg
// Description : Shared types and constants for the System Bus Access engine.
// Revision    : 1.0 - initial release
// ============================================================================
package sba_pkg;

   typedef enum logic [2:0] {
      ERR_NONE    = 3'd0,
      ERR_TIMEOUT = 3'd1,
      ERR_ALIGN   = 3'd3,
      ERR_SIZE    = 3'd4
   } sberror_e;

   localparam int c_SBCS_BUSYERROR  = 22;
   localparam int c_SBCS_BUSY       = 21;
   localparam int c_SBCS_READONADDR = 20;
   localparam int c_SBCS_ACCESS_LSB = 17;
   localparam int c_SBCS_AUTOINC    = 16;
   localparam int c_SBCS_READONDATA = 15;
   localparam int c_SBCS_ERROR_LSB  = 12;
   localparam int c_SBCS_ASIZE_LSB  = 5;
   localparam int c_SBCS_VER_LSB    = 29;

   localparam logic [2:0] c_ACCESS_8  = 3'd0;
   localparam logic [2:0] c_ACCESS_16 = 3'd1;
   localparam logic [2:0] c_ACCESS_32 = 3'd2;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REQ_RD = 2'd1,
      S_REQ_WR = 2'd2
   } sba_state_e;

endpackage
`default_nettype wire

// File: rtl/sba_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : sba_lane_align
// Description : Byte-lane steering: enables, write replication, read extract.
// Revision    : 1.0 - initial release
// ============================================================================
module sba_lane_align
   import sba_pkg::*;
(
   input  logic [1:0]  i_addr_lo,
   input  logic [2:0]  i_access,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata
);

   logic [31:0] w_shifted;

   always_comb begin
      w_shifted = i_rdata >> {i_addr_lo, 3'b000};
      o_be      = 4'hF;
      o_wdata   = i_wdata;
      o_rdata   = w_shifted;
      case (i_access)
         c_ACCESS_8: begin
            o_be    = 4'b0001 << i_addr_lo;
            o_wdata = {4{i_wdata[7:0]}};
            o_rdata = {24'd0, w_shifted[7:0]};
         end
         c_ACCESS_16: begin
            o_be    = 4'b0011 << i_addr_lo;
            o_wdata = {2{i_wdata[15:0]}};
            o_rdata = {16'd0, w_shifted[15:0]};
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/sba_master.sv
`default_nettype none
// ============================================================================
// Module      : sba_master
// Description : Debug-module SBA engine turning sbcs/sbaddress0/sbdata0
//               accesses into single-beat system bus reads and writes.
// Revision    : 1.0 - initial release
// ============================================================================
module sba_master
   import sba_pkg::*;
#(
   parameter int TimeoutCycles = 256,
   parameter int XLEN          = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] dm_wdata,
   input  logic            sbcs_write,
   input  logic            sbaddress0_write,
   input  logic            sbdata0_write,
   input  logic            sbdata0_read,
   output logic [31:0]     sbcs_rdata,
   output logic [XLEN-1:0] sbaddress0_rdata,
   output logic [XLEN-1:0] sbdata0_rdata,
   output logic [XLEN-1:0] bus_addr,
   output logic [XLEN-1:0] bus_wdata,
   output logic [3:0]      bus_be,
   output logic            bus_rd,
   output logic            bus_wr,
   input  logic [XLEN-1:0] bus_rdata,
   input  logic            bus_ack
);

   localparam int             c_TW         = $clog2(TimeoutCycles + 1);
   localparam logic [c_TW-1:0] c_TIMER_LAST = c_TW'(TimeoutCycles - 1);

   sba_state_e      r_state;
   logic [c_TW-1:0] r_timer;
   logic [XLEN-1:0] r_addr;
   logic [XLEN-1:0] r_data;
   logic            r_readonaddr;
   logic [2:0]      r_access;
   logic            r_autoinc;
   logic            r_readondata;
   logic [2:0]      r_sberror;
   logic            r_busyerror;

   logic            w_busy;
   logic            w_go;
   logic            w_addr_strobe;
   logic            w_wdata_strobe;
   logic            w_rdata_strobe;
   logic            w_start_rd;
   logic            w_start_wr;
   logic [XLEN-1:0] w_start_addr;
   logic            w_size_err;
   logic            w_align_err;
   logic [1:0]      w_lane_addr;
   logic [3:0]      w_be;
   logic [31:0]     w_lane_wdata;
   logic [31:0]     w_lane_rdata;
   logic [XLEN-1:0] w_incr;

   // Strobe priority: sbcs > sbaddress0 write > sbdata0 write > sbdata0 read.
   assign w_busy         = (r_state != S_IDLE);
   assign w_go           = (r_sberror == ERR_NONE) && !r_busyerror;
   assign w_addr_strobe  = sbaddress0_write && !sbcs_write;
   assign w_wdata_strobe = sbdata0_write && !sbcs_write && !sbaddress0_write;
   assign w_rdata_strobe = sbdata0_read && !sbcs_write && !sbaddress0_write && !sbdata0_write;
   assign w_start_rd     = !w_busy && w_go &&
                           ((w_addr_strobe && r_readonaddr) || (w_rdata_strobe && r_readondata));
   assign w_start_wr     = !w_busy && w_go && w_wdata_strobe;
   assign w_start_addr   = w_addr_strobe ? dm_wdata : r_addr;
   assign w_size_err     = (r_access > c_ACCESS_32);
   assign w_align_err    = ((r_access == c_ACCESS_16) && w_start_addr[0]) ||
                           ((r_access == c_ACCESS_32) && (w_start_addr[1:0] != 2'b00));
   // While a request is outstanding the held address selects the read lanes.
   assign w_lane_addr    = w_busy ? r_addr[1:0] : w_start_addr[1:0];
   assign w_incr         = XLEN'(1) << r_access;

   sba_lane_align u_lane_align (
      .i_addr_lo (w_lane_addr),
      .i_access  (r_access),
      .i_wdata   (dm_wdata),
      .i_rdata   (bus_rdata),
      .o_be      (w_be),
      .o_wdata   (w_lane_wdata),
      .o_rdata   (w_lane_rdata)
   );

   always_comb begin
      sbcs_rdata                                         = 32'd0;
      sbcs_rdata[c_SBCS_VER_LSB +: 3]                    = 3'd1;
      sbcs_rdata[c_SBCS_BUSYERROR]                       = r_busyerror;
      sbcs_rdata[c_SBCS_BUSY]                            = w_busy;
      sbcs_rdata[c_SBCS_READONADDR]                      = r_readonaddr;
      sbcs_rdata[c_SBCS_ACCESS_LSB +: 3]                 = r_access;
      sbcs_rdata[c_SBCS_AUTOINC]                         = r_autoinc;
      sbcs_rdata[c_SBCS_READONDATA]                      = r_readondata;
      sbcs_rdata[c_SBCS_ERROR_LSB +: 3]                  = r_sberror;
      sbcs_rdata[c_SBCS_ASIZE_LSB +: 7]                  = 7'd32;
      sbcs_rdata[2:0]                                    = 3'b111;
   end

   assign sbaddress0_rdata = r_addr;
   assign sbdata0_rdata    = r_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_timer      <= '0;
         r_addr       <= '0;
         r_data       <= '0;
         r_readonaddr <= 1'b0;
         r_access     <= 3'd0;
         r_autoinc    <= 1'b0;
         r_readondata <= 1'b0;
         r_sberror    <= ERR_NONE;
         r_busyerror  <= 1'b0;
         bus_addr     <= '0;
         bus_wdata    <= '0;
         bus_be       <= 4'd0;
         bus_rd       <= 1'b0;
         bus_wr       <= 1'b0;
      end else begin
         if (sbcs_write) begin
            r_sberror   <= r_sberror & ~dm_wdata[c_SBCS_ERROR_LSB +: 3];
            r_busyerror <= r_busyerror & ~dm_wdata[c_SBCS_BUSYERROR];
         end
         case (r_state)
            S_IDLE: begin
               if (sbcs_write) begin
                  r_readonaddr <= dm_wdata[c_SBCS_READONADDR];
                  r_access     <= dm_wdata[c_SBCS_ACCESS_LSB +: 3];
                  r_autoinc    <= dm_wdata[c_SBCS_AUTOINC];
                  r_readondata <= dm_wdata[c_SBCS_READONDATA];
               end else if (w_addr_strobe) begin
                  r_addr <= dm_wdata;
               end else if (w_wdata_strobe) begin
                  r_data <= dm_wdata;
               end
               if (w_start_rd || w_start_wr) begin
                  if (w_size_err) begin
                     r_sberror <= ERR_SIZE;
                  end else if (w_align_err) begin
                     r_sberror <= ERR_ALIGN;
                  end else begin
                     r_state   <= w_start_rd ? S_REQ_RD : S_REQ_WR;
                     bus_rd    <= w_start_rd;
                     bus_wr    <= w_start_wr;
                     bus_addr  <= {w_start_addr[XLEN-1:2], 2'b00};
                     bus_be    <= w_be;
                     bus_wdata <= w_lane_wdata;
                     r_timer   <= '0;
                  end
               end
            end
            S_REQ_RD, S_REQ_WR: begin
               if (w_addr_strobe || w_wdata_strobe || w_rdata_strobe) begin
                  r_busyerror <= 1'b1;
               end
               // An ack in the final timeout cycle still completes the access.
               if (bus_ack) begin
                  r_state <= S_IDLE;
                  bus_rd  <= 1'b0;
                  bus_wr  <= 1'b0;
                  if (r_state == S_REQ_RD) begin
                     r_data <= w_lane_rdata;
                  end
                  if (r_autoinc) begin
                     r_addr <= r_addr + w_incr;
                  end
               end else if (r_timer == c_TIMER_LAST) begin
                  r_state   <= S_IDLE;
                  bus_rd    <= 1'b0;
                  bus_wr    <= 1'b0;
                  r_sberror <= ERR_TIMEOUT;
               end else begin
                  r_timer <= r_timer + c_TW'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               bus_rd  <= 1'b0;
               bus_wr  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sba_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_sba_master
// Description : Self-checking bench for sba_master (vectors, directed, random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sba_master;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] dm_wdata = '0;
   logic        sbcs_write = 1'b0, sbaddress0_write = 1'b0;
   logic        sbdata0_write = 1'b0, sbdata0_read = 1'b0;
   logic [31:0] sbcs_rdata, sbaddress0_rdata, sbdata0_rdata;
   logic [31:0] bus_addr, bus_wdata, bus_rdata = '0;
   logic [3:0]  bus_be;
   logic        bus_rd, bus_wr, bus_ack = 1'b0;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sba_master #(.TimeoutCycles(8), .XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .dm_wdata(dm_wdata),
      .sbcs_write(sbcs_write), .sbaddress0_write(sbaddress0_write),
      .sbdata0_write(sbdata0_write), .sbdata0_read(sbdata0_read),
      .sbcs_rdata(sbcs_rdata), .sbaddress0_rdata(sbaddress0_rdata),
      .sbdata0_rdata(sbdata0_rdata), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_be(bus_be), .bus_rd(bus_rd), .bus_wr(bus_wr),
      .bus_rdata(bus_rdata), .bus_ack(bus_ack)
   );

   typedef struct {
      logic [2:0]  acc;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // which: 0=sbcs write, 1=sbaddress0 write, 2=sbdata0 write, 3=sbdata0 read
   task automatic strobe(input int which, input logic [31:0] d);
      dm_wdata         = d;
      sbcs_write       = (which == 0);
      sbaddress0_write = (which == 1);
      sbdata0_write    = (which == 2);
      sbdata0_read     = (which == 3);
      tick();
      sbcs_write = 1'b0; sbaddress0_write = 1'b0;
      sbdata0_write = 1'b0; sbdata0_read = 1'b0;
   endtask

   task automatic ack(input logic [31:0] rd);
      bus_rdata = rd;
      bus_ack   = 1'b1;
      tick();
      bus_ack   = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   function automatic logic [31:0] sbcs_exp(input logic berr, input logic busy, input logic roa,
                                            input logic [2:0] acc, input logic ainc,
                                            input logic rod, input logic [2:0] err);
      return {3'd1, 6'd0, berr, busy, roa, acc, ainc, rod, err, 7'd32, 2'd0, 3'b111};
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  acc;
      logic        ainc, is_rd;
      logic [31:0] addr, data, rdv, m_addr, m_data;
      logic [2:0]  exp_err;
      logic [63:0] mask;
      int          size, off;

      vecs[0] = '{3'd0, 32'h10, 32'h000000A5, 32'h11223344, 32'h10, 4'b0001, 32'hA5A5A5A5, 32'h44};
      vecs[1] = '{3'd0, 32'h12, 32'h0000003C, 32'h11223344, 32'h10, 4'b0100, 32'h3C3C3C3C, 32'h22};
      vecs[2] = '{3'd1, 32'h22, 32'h0000BEEF, 32'hCAFEF00D, 32'h20, 4'b1100, 32'hBEEFBEEF, 32'hCAFE};
      vecs[3] = '{3'd1, 32'h20, 32'h00001234, 32'hCAFEF00D, 32'h20, 4'b0011, 32'h12341234, 32'hF00D};
      vecs[4] = '{3'd2, 32'h30, 32'h89ABCDEF, 32'h0BADF00D, 32'h30, 4'b1111, 32'h89ABCDEF, 32'h0BADF00D};
      vecs[5] = '{3'd0, 32'h43, 32'h12345677, 32'h99000000, 32'h40, 4'b1000, 32'h77777777, 32'h99};

      do_reset();
      check("reset_sbcs", sbcs_rdata, 32'h20000407);
      check("reset_rd_wr", {30'd0, bus_rd, bus_wr}, 32'd0);
      check("reset_bus_addr", bus_addr, 32'd0);
      check("reset_bus_be", {28'd0, bus_be}, 32'd0);
      check("reset_bus_wdata", bus_wdata, 32'd0);
      check("reset_addr", sbaddress0_rdata, 32'd0);
      check("reset_data", sbdata0_rdata, 32'd0);

      // Read-on-address word access with ack after three cycles
      strobe(0, 32'h0014_0000);
      check("t1_sbcs", sbcs_rdata, sbcs_exp(0, 0, 1, 3'd2, 0, 0, 3'd0));
      strobe(1, 32'h1000);
      check("t1_rd", {31'd0, bus_rd}, 32'd1);
      check("t1_bus_addr", bus_addr, 32'h1000);
      check("t1_be", {28'd0, bus_be}, 32'hF);
      tick(); tick();
      check("t1_busy_in_ack", sbcs_rdata, sbcs_exp(0, 1, 1, 3'd2, 0, 0, 3'd0));
      ack(32'hDEADBEEF);
      check("t1_data", sbdata0_rdata, 32'hDEADBEEF);
      check("t1_idle", sbcs_rdata, sbcs_exp(0, 0, 1, 3'd2, 0, 0, 3'd0));
      check("t1_rd_drop", {31'd0, bus_rd}, 32'd0);
      ack(32'h01234567);
      check("t1_ack_idle_ignored", sbdata0_rdata, 32'hDEADBEEF);

      // Byte write with autoincrement
      strobe(0, 32'h0001_0000);
      strobe(1, 32'h2003);
      strobe(2, 32'h5A);
      check("t2_wr", {31'd0, bus_wr}, 32'd1);
      check("t2_bus_addr", bus_addr, 32'h2000);
      check("t2_be", {28'd0, bus_be}, 32'h8);
      check("t2_wdata", bus_wdata, 32'h5A5A5A5A);
      ack(32'h0);
      check("t2_autoinc", sbaddress0_rdata, 32'h2004);
      check("t2_wr_drop", {31'd0, bus_wr}, 32'd0);

      // Alignment and size errors, W1C clear
      strobe(0, 32'h0012_0000);
      strobe(1, 32'h3001);
      check("t3_align_nord", {31'd0, bus_rd}, 32'd0);
      check("t3_align_err", sbcs_rdata, sbcs_exp(0, 0, 1, 3'd1, 0, 0, 3'd3));
      strobe(0, 32'h0012_7000);
      check("t3_w1c", sbcs_rdata, sbcs_exp(0, 0, 1, 3'd1, 0, 0, 3'd0));
      strobe(0, 32'h001A_0000);
      strobe(1, 32'h3000);
      check("t3_size_nord", {31'd0, bus_rd}, 32'd0);
      check("t3_size_err", sbcs_rdata, sbcs_exp(0, 0, 1, 3'd5, 0, 0, 3'd4));
      strobe(0, 32'h0000_7000);
      check("t3_w1c2", sbcs_rdata, sbcs_exp(0, 0, 0, 3'd0, 0, 0, 3'd0));

      // Timeout after eight request cycles
      strobe(0, 32'h0014_0000);
      strobe(1, 32'h4000);
      repeat (7) tick();
      check("t4_still_req", {31'd0, bus_rd}, 32'd1);
      tick();
      check("t4_dropped", {31'd0, bus_rd}, 32'd0);
      check("t4_err", sbcs_rdata, sbcs_exp(0, 0, 1, 3'd2, 0, 0, 3'd1));
      strobe(2, 32'h1111);
      check("t4_blocked", {31'd0, bus_wr}, 32'd0);
      check("t4_data_loaded", sbdata0_rdata, 32'h1111);
      strobe(0, 32'h0000_7000);

      // Busy violation during outstanding read
      strobe(0, 32'h0014_0000);
      strobe(1, 32'h5000);
      strobe(1, 32'h6000);
      check("t5_busyerr", sbcs_rdata, sbcs_exp(1, 1, 1, 3'd2, 0, 0, 3'd0));
      check("t5_addr_kept", sbaddress0_rdata, 32'h5000);
      check("t5_bus_addr_kept", bus_addr, 32'h5000);
      ack(32'h600DF00D);
      check("t5_read_done", sbdata0_rdata, 32'h600DF00D);
      strobe(1, 32'h5004);
      check("t5_blocked", {31'd0, bus_rd}, 32'd0);
      check("t5_addr_loaded", sbaddress0_rdata, 32'h5004);
      strobe(0, 32'h0054_0000);
      check("t5_w1c", sbcs_rdata, sbcs_exp(0, 0, 1, 3'd2, 0, 0, 3'd0));
      strobe(1, 32'h5008);
      check("t5_resume", {31'd0, bus_rd}, 32'd1);
      ack(32'h0);

      // Lane steering vectors
      foreach (vecs[i]) begin
         strobe(0, (32'(vecs[i].acc) << 17) | 32'h8000);
         strobe(1, vecs[i].addr);
         strobe(2, vecs[i].wdata);
         check($sformatf("vec%0d_wr", i), {31'd0, bus_wr}, 32'd1);
         check($sformatf("vec%0d_addr", i), bus_addr, vecs[i].exp_addr);
         check($sformatf("vec%0d_be", i), {28'd0, bus_be}, {28'd0, vecs[i].exp_be});
         check($sformatf("vec%0d_wdata", i), bus_wdata, vecs[i].exp_wdata);
         ack(32'h0);
         strobe(3, 32'h0);
         check($sformatf("vec%0d_rd", i), {31'd0, bus_rd}, 32'd1);
         check($sformatf("vec%0d_old", i), sbdata0_rdata, vecs[i].wdata);
         ack(vecs[i].rdata);
         check($sformatf("vec%0d_rdata", i), sbdata0_rdata, vecs[i].exp_rdata);
      end

      // Randomized accesses against a transaction-level model
      m_data = sbdata0_rdata;
      for (int it = 0; it < 60; it++) begin
         acc   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         ainc  = 1'($urandom_range(0, 1));
         is_rd = 1'($urandom_range(0, 1));
         addr  = $urandom;
         size  = (acc <= 3'd2) ? (1 << acc) : 1;
         if (acc <= 3'd2 && $urandom_range(0, 3) != 0) addr = addr & ~(32'(size) - 32'd1);
         data  = $urandom;
         rdv   = $urandom;
         off   = int'(addr % 4);
         if (acc > 3'd2)                 exp_err = 3'd4;
         else if (addr % size != 0)      exp_err = 3'd3;
         else                            exp_err = 3'd0;

         strobe(0, (32'(acc) << 17) | (32'(ainc) << 16) | (32'(is_rd) << 20));
         strobe(1, addr);
         m_addr = addr;
         if (!is_rd) begin
            strobe(2, data);
            m_data = data;
         end
         check("rnd_rd", {31'd0, bus_rd}, {31'd0, is_rd && exp_err == 3'd0});
         check("rnd_wr", {31'd0, bus_wr}, {31'd0, !is_rd && exp_err == 3'd0});
         if (exp_err != 3'd0) begin
            check("rnd_err", sbcs_rdata, sbcs_exp(0, 0, is_rd, acc, ainc, 0, exp_err));
            strobe(0, 32'h0000_7000);
         end else begin
            check("rnd_bus_addr", bus_addr, addr & 32'hFFFF_FFFC);
            check("rnd_be", {28'd0, bus_be}, ((32'd1 << size) - 32'd1) << off);
            if (!is_rd) begin
               if (size == 1)      check("rnd_wdata", bus_wdata, 32'(data[7:0]) * 32'h01010101);
               else if (size == 2) check("rnd_wdata", bus_wdata, 32'(data[15:0]) * 32'h00010001);
               else                check("rnd_wdata", bus_wdata, data);
            end
            repeat ($urandom_range(0, 3)) tick();
            ack(rdv);
            mask = (64'd1 << (8 * size)) - 64'd1;
            if (is_rd) m_data = (rdv >> (8 * off)) & mask[31:0];
            if (ainc)  m_addr = m_addr + 32'(size);
            check("rnd_sbcs", sbcs_rdata, sbcs_exp(0, 0, is_rd, acc, ainc, 0, 3'd0));
         end
         check("rnd_addr", sbaddress0_rdata, m_addr);
         check("rnd_data", sbdata0_rdata, m_data);
      end

      // Asynchronous reset while a write is outstanding
      strobe(0, 32'h0004_0000);
      strobe(1, 32'h7000);
      strobe(2, 32'hABCD1234);
      check("t6_wr_before", {31'd0, bus_wr}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_wr_async", {31'd0, bus_wr}, 32'd0);
      check("t6_sbcs", sbcs_rdata, 32'h20000407);
      check("t6_addr", sbaddress0_rdata, 32'd0);
      check("t6_data", sbdata0_rdata, 32'd0);
      check("t6_be", {28'd0, bus_be}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
